// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: mul/div opcodes, FSM states,
// ctrl bundle bit positions and the ALU function codes.
package ex_pkg;

  localparam logic [2:0] MD_NONE = 3'd0;
  localparam logic [2:0] MD_MULT = 3'd1;
  localparam logic [2:0] MD_DIV  = 3'd2;
  localparam logic [2:0] MD_MFHI = 3'd3;
  localparam logic [2:0] MD_MFLO = 3'd4;
  localparam logic [2:0] MD_MTHI = 3'd5;
  localparam logic [2:0] MD_MTLO = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // ctrl_in = {MemWrite, MemRead, MemToReg[1:0], RegWrite, LUOp, 2'b0}
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_LUOP     = 2;

  localparam logic [5:0] ALU_ADD = 6'h00;
  localparam logic [5:0] ALU_SUB = 6'h01;
  localparam logic [5:0] ALU_AND = 6'h18;
  localparam logic [5:0] ALU_OR  = 6'h1E;
  localparam logic [5:0] ALU_XOR = 6'h16;
  localparam logic [5:0] ALU_NOR = 6'h11;
  localparam logic [5:0] ALU_SLL = 6'h20;
  localparam logic [5:0] ALU_SRL = 6'h21;
  localparam logic [5:0] ALU_SRA = 6'h23;
  localparam logic [5:0] ALU_EQ  = 6'h33;
  localparam logic [5:0] ALU_NE  = 6'h31;
  localparam logic [5:0] ALU_LT  = 6'h35;

endpackage

// File: rtl/alu.sv
// Combinational ALU; compare functions return their flag in bit 0.
module alu
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [5:0]        fun,
  input  logic              sign,
  output logic [DATA_W-1:0] s
);

  logic lt;

  // function select; shifts take the amount from a[4:0]
  always_comb begin
    lt = sign ? ($signed(a) < $signed(b)) : (a < b);
    s  = '0;
    case (fun)
      ALU_ADD: s = a + b;
      ALU_SUB: s = a - b;
      ALU_AND: s = a & b;
      ALU_OR:  s = a | b;
      ALU_XOR: s = a ^ b;
      ALU_NOR: s = ~(a | b);
      ALU_SLL: s = b << a[4:0];
      ALU_SRL: s = b >> a[4:0];
      ALU_SRA: s = $signed(b) >>> a[4:0];
      ALU_EQ:  s = {{(DATA_W-1){1'b0}}, a == b};
      ALU_NE:  s = {{(DATA_W-1){1'b0}}, a != b};
      ALU_LT:  s = {{(DATA_W-1){1'b0}}, lt};
      default: s = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply / divide on operand magnitudes, one bit per cycle.
// Signs are applied to the final HI/LO view, so acc/q are always unsigned.
module md_unit #(
  parameter int DATA_W = 32,
  localparam int CW = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              run,
  input  logic              sign,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              last,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mb, acc, q, orig_a, diff;
  logic [DATA_W:0]   sum, sh;
  logic              div_r, neg_lo, neg_hi, dz, ge;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [2*DATA_W-1:0] prod;

  assign a_neg = sign && a[DATA_W-1];
  assign b_neg = sign && b[DATA_W-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;
  assign last  = run && (cnt == CW'(DATA_W-1));

  // single step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    sum  = {1'b0, acc} + (q[0] ? {1'b0, mb} : '0);
    sh   = {acc, q[DATA_W-1]};
    ge   = sh >= {1'b0, mb};
    diff = sh[DATA_W-1:0] - mb;
  end

  // operand latch on start, then iterate while the FSM is in RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0; mb <= '0; acc <= '0; q <= '0; orig_a <= '0;
      div_r <= 1'b0; neg_lo <= 1'b0; neg_hi <= 1'b0; dz <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      mb     <= abs_b;
      acc    <= '0;
      q      <= abs_a;
      orig_a <= a;
      div_r  <= is_div;
      neg_lo <= a_neg ^ b_neg;  // product sign, or quotient sign
      neg_hi <= a_neg;          // remainder follows the dividend
      dz     <= is_div && (b == '0);
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (div_r) begin
        acc <= ge ? diff : sh[DATA_W-1:0];
        q   <= {q[DATA_W-2:0], ge};
      end else begin
        acc <= sum[DATA_W:1];
        q   <= {sum[0], q[DATA_W-1:1]};
      end
    end
  end

  // signed HI/LO view; divide by zero returns all-ones / dividend
  always_comb begin
    prod = neg_lo ? -{acc, q} : {acc, q};
    if (dz) begin
      hi = orig_a;
      lo = '1;
    end else if (div_r) begin
      hi = neg_hi ? -acc : acc;
      lo = neg_lo ? -q : q;
    end else begin
      hi = prod[2*DATA_W-1:DATA_W];
      lo = prod[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, ALU, HI/LO with an iterative mul/div,
// and a valid/ready EX/MEM output register.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [REG_AW-1:0]         rs,
  input  logic [REG_AW-1:0]         rt,
  input  logic [REG_AW-1:0]         wr_reg,
  input  logic [DATA_W-1:0]         rs_data,
  input  logic [DATA_W-1:0]         rt_data,
  input  logic [4:0]                shamt,
  input  logic [DATA_W-1:0]         imm,
  input  logic                      alu_src1,
  input  logic                      alu_src2,
  input  logic [5:0]                alu_fun,
  input  logic                      sign,
  input  logic                      branch,
  input  logic [2:0]                md_op,
  input  logic [7:0]                ctrl_in,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      flush,
  input  logic                      mem_ready,
  output logic                      pcsrc_b,
  output logic                      ex_valid,
  output logic [DATA_W-1:0]         ex_result,
  output logic [DATA_W-1:0]         ex_store,
  output logic [REG_AW-1:0]         ex_wr_reg,
  output logic [7:0]                ex_ctrl,
  output logic                      md_busy
);

  md_state_t         state, state_nx;
  logic [DATA_W-1:0] rs_f, rt_f, alu_a, alu_b, alu_s, hi, lo, md_hi, md_lo;
  logic [7:0]        md_ctrl;
  logic [REG_AW-1:0] md_wr;
  logic              advance, xfer, start, md_run, md_last, done_fire;

  // forwarding: scan oldest to youngest so the lowest matching index wins
  always_comb begin
    rs_f = rs_data;
    rt_f = rt_data;
    for (int i = NUM_FWD-1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_rd[i*REG_AW +: REG_AW] != '0) begin
        if (fwd_rd[i*REG_AW +: REG_AW] == rs) rs_f = fwd_data[i*DATA_W +: DATA_W];
        if (fwd_rd[i*REG_AW +: REG_AW] == rt) rt_f = fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign alu_a = alu_src1 ? {{(DATA_W-5){1'b0}}, shamt} : rs_f;
  assign alu_b = alu_src2 ? imm : rt_f;

  alu #(.DATA_W(DATA_W)) u_alu (
    .a(alu_a), .b(alu_b), .fun(alu_fun), .sign(sign), .s(alu_s)
  );

  md_unit #(.DATA_W(DATA_W)) u_md (
    .clk(clk), .reset(reset), .start(start), .run(md_run),
    .sign(sign), .is_div(md_op == MD_DIV), .a(rs_f), .b(rt_f),
    .last(md_last), .hi(md_hi), .lo(md_lo)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // FSM next state; DONE waits for the output register to be free
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start)   state_nx = ST_RUN;
      ST_RUN:  if (md_last) state_nx = ST_DONE;
      ST_DONE: if (advance) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
  end

  // FSM outputs and handshake
  always_comb begin
    advance   = !ex_valid || mem_ready;
    id_ready  = (state == ST_IDLE) && advance && !flush;
    xfer      = id_valid && id_ready;
    start     = xfer && (md_op == MD_MULT || md_op == MD_DIV);
    md_run    = (state == ST_RUN);
    md_busy   = (state != ST_IDLE);
    done_fire = (state == ST_DONE) && advance && !flush;
    pcsrc_b   = xfer && branch && alu_s[0];
  end

  // HI/LO and the ctrl/destination of the mul/div in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0; lo <= '0; md_ctrl <= '0; md_wr <= '0;
    end else begin
      if (start) begin
        md_ctrl <= ctrl_in;
        md_wr   <= wr_reg;
      end
      if (done_fire) begin
        hi <= md_hi;
        lo <= md_lo;
      end else if (xfer && md_op == MD_MTHI) begin
        hi <= rs_f;
      end else if (xfer && md_op == MD_MTLO) begin
        lo <= rs_f;
      end
    end
  end

  // EX/MEM register: holds while MEM stalls, bubbles when nothing arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0; ex_result <= '0; ex_store <= '0; ex_wr_reg <= '0; ex_ctrl <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      if (done_fire) begin
        ex_valid  <= 1'b1;
        ex_result <= '0;
        ex_store  <= '0;
        ex_wr_reg <= md_wr;
        ex_ctrl   <= md_ctrl;
        ex_ctrl[CTRL_REGWRITE] <= 1'b0;
      end else if (xfer && !start) begin
        ex_valid  <= 1'b1;
        ex_result <= (md_op == MD_MFHI) ? hi : (md_op == MD_MFLO) ? lo : alu_s;
        ex_store  <= rt_f;
        ex_wr_reg <= wr_reg;
        ex_ctrl   <= ctrl_in;
      end else begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed + random bench for ex_stage_md with a behavioural HI/LO/ALU model.
module tb_ex_stage_md;
  import ex_pkg::*;

  localparam int W = 32, AW = 5, NF = 2;

  logic clk = 1'b0;
  logic reset, id_valid, id_ready, alu_src1, alu_src2, sign, branch, flush, mem_ready;
  logic pcsrc_b, ex_valid, md_busy;
  logic [AW-1:0] rs, rt, wr_reg, ex_wr_reg;
  logic [W-1:0] rs_data, rt_data, imm, ex_result, ex_store;
  logic [4:0] shamt;
  logic [5:0] alu_fun;
  logic [2:0] md_op;
  logic [7:0] ctrl_in, ex_ctrl;
  logic [NF-1:0] fwd_we;
  logic [NF*AW-1:0] fwd_rd;
  logic [NF*W-1:0] fwd_data;

  always #5 clk = ~clk;

  ex_stage_md #(.DATA_W(W), .REG_AW(AW), .NUM_FWD(NF)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .rs(rs), .rt(rt), .wr_reg(wr_reg), .rs_data(rs_data), .rt_data(rt_data),
    .shamt(shamt), .imm(imm), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_fun(alu_fun), .sign(sign), .branch(branch), .md_op(md_op), .ctrl_in(ctrl_in),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
    .mem_ready(mem_ready), .pcsrc_b(pcsrc_b), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store(ex_store), .ex_wr_reg(ex_wr_reg), .ex_ctrl(ex_ctrl), .md_busy(md_busy)
  );

  int nchk = 0, nerr = 0;
  logic [W-1:0] mhi = '0, mlo = '0;
  logic [5:0] funs [12] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
                            ALU_SLL, ALU_SRL, ALU_SRA, ALU_EQ, ALU_NE, ALU_LT};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    id_valid = 0; rs = 1; rt = 2; wr_reg = 3; rs_data = 0; rt_data = 0; shamt = 0; imm = 0;
    alu_src1 = 0; alu_src2 = 0; alu_fun = ALU_ADD; sign = 0; branch = 0; md_op = MD_NONE;
    ctrl_in = 8'h08; fwd_we = 0; fwd_rd = 0; fwd_data = 0; flush = 0; mem_ready = 1;
  endtask

  // reference: the youngest enabled, non-zero matching source supplies the operand
  function automatic logic [31:0] fwd_ref(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return rf;
    for (int i = 0; i < NF; i++)
      if (fwd_we[i] && fwd_rd[i*AW +: AW] == idx) return fwd_data[i*W +: W];
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic sg);
    case (f)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_NOR: return ~(a | b);
      ALU_SLL: return b << a[4:0];
      ALU_SRL: return b >> a[4:0];
      ALU_SRA: return 32'($signed(b) >>> a[4:0]);
      ALU_EQ:  return (a == b) ? 1 : 0;
      ALU_NE:  return (a != b) ? 1 : 0;
      ALU_LT:  return (sg ? ($signed(a) < $signed(b)) : (a < b)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // HI/LO after MULT/DIV, from 64-bit arithmetic
  task automatic md_ref(input logic [2:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
    if (op == MD_MULT) begin
      sp = sa * sb; up = 64'(sp);
      mhi = up[63:32]; mlo = up[31:0];
    end else if (b == 0) begin
      mhi = a; mlo = 32'hFFFF_FFFF;
    end else begin
      sq = sa / sb; sr = sa % sb;
      mlo = 32'(sq); mhi = 32'(sr);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!id_ready && n < 200) begin tick(); n++; end
    chk({tag, "_rdy"}, 32'(id_ready), 1);
  endtask

  task automatic issue(input logic [2:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b, input string tag);
    wait_ready(tag);
    id_valid = 1; md_op = op; alu_fun = ALU_ADD; sign = sg; rs = 1; rt = 2;
    rs_data = a; rt_data = b; fwd_we = 0; alu_src1 = 0; alu_src2 = 0; branch = 0;
    tick();
    id_valid = 0; md_op = MD_NONE;
  endtask

  task automatic check_hilo(input string tag);
    issue(MD_MFHI, 0, 0, 0, {tag, "_mfhi"});
    chk({tag, "_hi"}, ex_result, mhi);
    issue(MD_MFLO, 0, 0, 0, {tag, "_mflo"});
    chk({tag, "_lo"}, ex_result, mlo);
  endtask

  task automatic run_md(input logic [2:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n = 0;
    issue(op, sg, a, b, tag);
    chk({tag, "_busy"}, 32'(md_busy), 1);
    while (!id_ready && n < 100) begin tick(); n++; end
    chk({tag, "_lat"}, n, 33);
    chk({tag, "_dvalid"}, 32'(ex_valid), 1);
    chk({tag, "_dres"}, ex_result, 0);
    chk({tag, "_drw"}, 32'(ex_ctrl[CTRL_REGWRITE]), 0);
    md_ref(op, sg, a, b);
    check_hilo(tag);
  endtask

  initial begin
    logic [31:0] ea, eb, er, rsv, rtv, hold;
    logic [2:0] rop;
    logic rsg;

    // reset
    idle_in(); reset = 1;
    tick(); tick();
    reset = 0;
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_result", ex_result, 0);
    chk("rst_ctrl", 32'(ex_ctrl), 0);
    chk("rst_busy", 32'(md_busy), 0);
    chk("rst_ready", 32'(id_ready), 1);
    chk("rst_pcsrc", 32'(pcsrc_b), 0);
    check_hilo("rst");

    // forwarding priority: index 0 beats index 1
    id_valid = 1; rs = 5; rt = 5; rs_data = 32'h100; rt_data = 32'h200; alu_fun = ALU_ADD;
    fwd_we = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_data = {32'h22, 32'h11};
    tick();
    chk("fwd_prio_res", ex_result, 32'h22);
    chk("fwd_prio_store", ex_store, 32'h11);

    // disabled source skipped, register 0 never forwarded
    rs = 5; rt = 0; rt_data = 0; fwd_we = 2'b10; fwd_data = {32'h33, 32'h44};
    tick();
    chk("fwd_dis", ex_result, 32'h33);
    rs = 0; rs_data = 7; fwd_we = 2'b11; fwd_rd = {5'd0, 5'd0};
    tick();
    chk("fwd_zero", ex_result, 7);
    id_valid = 0; tick();
    chk("bubble", 32'(ex_valid), 0);

    // random ALU ops with random forwarding
    for (int k = 0; k < 24; k++) begin
      id_valid = 1; md_op = MD_NONE; branch = 1;
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      rs_data = $urandom; rt_data = $urandom;
      fwd_we = 2'($urandom); fwd_rd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_data = {$urandom, $urandom};
      alu_src1 = 1'($urandom); alu_src2 = 1'($urandom); shamt = 5'($urandom); imm = $urandom;
      sign = 1'($urandom); alu_fun = funs[$urandom_range(0, 11)];
      ctrl_in = 8'($urandom); wr_reg = 5'($urandom);
      rsv = fwd_ref(rs, rs_data); rtv = fwd_ref(rt, rt_data);
      ea = alu_src1 ? {27'b0, shamt} : rsv;
      eb = alu_src2 ? imm : rtv;
      er = alu_ref(alu_fun, ea, eb, sign);
      #1;
      chk($sformatf("rnd%0d_pcsrc", k), 32'(pcsrc_b), 32'(er[0]));
      tick();
      chk($sformatf("rnd%0d_res", k), ex_result, er);
      chk($sformatf("rnd%0d_store", k), ex_store, rtv);
      chk($sformatf("rnd%0d_wr", k), 32'(ex_wr_reg), 32'(wr_reg));
      chk($sformatf("rnd%0d_ctrl", k), 32'(ex_ctrl), 32'(ctrl_in));
    end
    idle_in(); tick();

    // mul/div directed
    run_md(MD_MULT, 1, -32'sd3, 32'd7, "mult_s");
    run_md(MD_DIV, 0, 32'd100, 32'd7, "divu");
    run_md(MD_DIV, 1, -32'sd7, 32'd2, "div_s");
    run_md(MD_DIV, 1, -32'sd5, 32'd0, "div_z");
    run_md(MD_DIV, 0, 32'hDEAD_BEEF, 32'd0, "divu_z");

    // random mul/div
    for (int k = 0; k < 8; k++) begin
      rop = (k % 2 == 0) ? MD_MULT : MD_DIV;
      rsg = 1'($urandom);
      ea = $urandom;
      eb = (k == 5) ? $urandom_range(1, 1000) : $urandom;
      run_md(rop, rsg, ea, eb, $sformatf("rmd%0d", k));
    end

    // MTHI / MTLO
    issue(MD_MTHI, 0, 32'h1234_5678, 0, "mthi"); mhi = 32'h1234_5678;
    issue(MD_MTLO, 0, 32'h9ABC_DEF0, 0, "mtlo"); mlo = 32'h9ABC_DEF0;
    check_hilo("mt");

    // MEM back-pressure
    issue(MD_NONE, 0, 32'h40, 32'h2, "stall_pre");
    hold = ex_result;
    chk("stall_pre_res", hold, 32'h42);
    mem_ready = 0; id_valid = 1; branch = 1; alu_fun = ALU_EQ; rs_data = 5; rt_data = 5;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_rdy", k), 32'(id_ready), 0);
      chk($sformatf("stall%0d_pc", k), 32'(pcsrc_b), 0);
      chk($sformatf("stall%0d_vld", k), 32'(ex_valid), 1);
      chk($sformatf("stall%0d_res", k), ex_result, hold);
      tick();
    end
    mem_ready = 1; #1;
    chk("release_rdy", 32'(id_ready), 1);
    chk("release_pc", 32'(pcsrc_b), 1);
    tick();
    chk("release_res", ex_result, 1);
    idle_in(); tick();

    // flush a DIV mid-flight: HI/LO keep the MT values
    issue(MD_DIV, 0, 32'd1000, 32'd3, "flush");
    for (int k = 0; k < 10; k++) tick();
    chk("flush_busy_pre", 32'(md_busy), 1);
    flush = 1; #1;
    chk("flush_rdy", 32'(id_ready), 0);
    tick();
    flush = 0;
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_busy", 32'(md_busy), 0);
    check_hilo("flush");

    // synchronous reset in the middle of a MULT
    issue(MD_MULT, 0, 32'd12345, 32'd678, "rstmul");
    for (int k = 0; k < 5; k++) tick();
    chk("rstmul_busy_pre", 32'(md_busy), 1);
    reset = 1; tick(); reset = 0;
    chk("rstmul_busy", 32'(md_busy), 0);
    chk("rstmul_valid", 32'(ex_valid), 0);
    chk("rstmul_res", ex_result, 0);
    mhi = 0; mlo = 0;
    check_hilo("rstmul");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
